// File: rtl/filter_test_sequencer.sv
// filter_test_sequencer: delay-sweep controller; drives test_* to exp_sig_gen, measures peak of filter_data lane cfg_filter_sel per step, returns result_* over valid/ready; busy/done/cfg_error status
module filter_test_sequencer #(
  parameter int NUM_FILTERS      = 6,
  parameter int SIZE_DELAY       = 8,
  parameter int SIZE_FILTER_DATA = 16,
  parameter int SETTLE_LEN       = 16,
  parameter int WINDOW_LEN       = 256
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic                                     start,
  input  logic                                     abort,
  input  logic [SIZE_DELAY-1:0]                    cfg_delay_start,
  input  logic [SIZE_DELAY-1:0]                    cfg_delay_stop,
  input  logic [SIZE_DELAY-1:0]                    cfg_delay_step,
  input  logic                                     cfg_overlay,
  input  logic                                     cfg_rate,
  input  logic [2:0]                               cfg_filter_sel,
  input  logic [NUM_FILTERS*SIZE_FILTER_DATA-1:0]  filter_data,
  output logic                                     test_overlay,
  output logic                                     test_rate,
  output logic [SIZE_DELAY-1:0]                    test_delay,
  output logic                                     result_valid,
  input  logic                                     result_ready,
  output logic [SIZE_DELAY-1:0]                    result_delay,
  output logic [SIZE_FILTER_DATA-1:0]              result_peak,
  output logic [$clog2(WINDOW_LEN)-1:0]            result_peak_idx,
  output logic                                     busy,
  output logic                                     done,
  output logic                                     cfg_error
);
  localparam int CW = $clog2(SETTLE_LEN > WINDOW_LEN ? SETTLE_LEN : WINDOW_LEN) + 1;
  localparam int IW = $clog2(WINDOW_LEN);
  typedef enum logic [2:0] {IDLE, SETTLE, MEASURE, REPORT, FINISH} state_t;
  state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic [SIZE_DELAY-1:0] start_q, stop_q, step_q;
  logic overlay_q, rate_q;
  logic [2:0] sel_q;
  logic signed [SIZE_FILTER_DATA-1:0] peak, sample;
  logic [IW-1:0] idx;
  logic [SIZE_DELAY:0] nxt;
  logic last, sel_ok;
  assign sel_ok = 32'(cfg_filter_sel) < NUM_FILTERS;
  assign nxt = {1'b0, test_delay} + {1'b0, step_q};
  assign last = nxt[SIZE_DELAY] || nxt > {1'b0, stop_q} || start_q > stop_q;
  always_comb begin
    sample = '0;
    for (int k = 0; k < NUM_FILTERS; k++)
      if (32'(sel_q) == k) sample = filter_data[k*SIZE_FILTER_DATA +: SIZE_FILTER_DATA];
  end
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = start && sel_ok ? SETTLE : IDLE;
      SETTLE:  state_nx = cnt == CW'(SETTLE_LEN - 1) ? MEASURE : SETTLE;
      MEASURE: state_nx = cnt == CW'(WINDOW_LEN - 1) ? REPORT : MEASURE;
      REPORT:  state_nx = result_ready ? (last ? FINISH : SETTLE) : REPORT;
      default: state_nx = IDLE;
    endcase
    if (abort) state_nx = IDLE;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      cnt <= '0;
      start_q <= '0;
      stop_q <= '0;
      step_q <= '0;
      overlay_q <= 1'b0;
      rate_q <= 1'b0;
      sel_q <= '0;
      test_delay <= '0;
      peak <= '0;
      idx <= '0;
      cfg_error <= 1'b0;
    end else begin
      cnt <= state_nx == state ? cnt + 1'b1 : '0;
      cfg_error <= state == IDLE && start && !abort && !sel_ok;
      if (state == IDLE && state_nx == SETTLE) begin
        start_q <= cfg_delay_start;
        stop_q <= cfg_delay_stop;
        step_q <= cfg_delay_step == '0 ? SIZE_DELAY'(1) : cfg_delay_step;
        overlay_q <= cfg_overlay;
        rate_q <= cfg_rate;
        sel_q <= cfg_filter_sel;
        test_delay <= cfg_delay_start;
      end
      if (state == SETTLE && state_nx == MEASURE) begin
        peak <= {1'b1, {(SIZE_FILTER_DATA-1){1'b0}}};
        idx <= '0;
      end
      if (state == MEASURE && sample > peak) begin
        peak <= sample;
        idx <= cnt[IW-1:0];
      end
      if (state == REPORT && state_nx == SETTLE) test_delay <= nxt[SIZE_DELAY-1:0];
    end
  assign busy = state != IDLE;
  assign done = state == FINISH;
  assign result_valid = state == REPORT;
  assign test_overlay = busy && overlay_q;
  assign test_rate = busy && rate_q;
  assign result_delay = test_delay;
  assign result_peak = peak;
  assign result_peak_idx = idx;
endmodule

// File: tb/tb_filter_test_sequencer.sv
// tb_filter_test_sequencer: randomized directed sweeps checked against a list/array reference model
module tb_filter_test_sequencer;
  localparam int NF = 6, SD = 8, FW = 16, SL = 16, WL = 256, IW = $clog2(WL);
  logic clk = 0, reset = 1, start = 0, abort = 0, result_ready = 0;
  logic [SD-1:0] cfg_delay_start = 0, cfg_delay_stop = 0, cfg_delay_step = 0;
  logic cfg_overlay = 0, cfg_rate = 0;
  logic [2:0] cfg_filter_sel = 0;
  logic [NF*FW-1:0] filter_data = '0;
  logic test_overlay, test_rate, result_valid, busy, done, cfg_error;
  logic [SD-1:0] test_delay, result_delay;
  logic [FW-1:0] result_peak;
  logic [IW-1:0] result_peak_idx;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  filter_test_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .cfg_delay_start(cfg_delay_start), .cfg_delay_stop(cfg_delay_stop), .cfg_delay_step(cfg_delay_step),
    .cfg_overlay(cfg_overlay), .cfg_rate(cfg_rate), .cfg_filter_sel(cfg_filter_sel),
    .filter_data(filter_data), .test_overlay(test_overlay), .test_rate(test_rate), .test_delay(test_delay),
    .result_valid(result_valid), .result_ready(result_ready), .result_delay(result_delay),
    .result_peak(result_peak), .result_peak_idx(result_peak_idx), .busy(busy), .done(done), .cfg_error(cfg_error)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [63:0] outs();
    return {18'b0, test_overlay, test_rate, test_delay, result_valid, result_delay, result_peak,
            result_peak_idx, busy, done, cfg_error};
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input int sel, input int val);
    for (int k = 0; k < NF; k++) filter_data[k*FW +: FW] = (k == sel) ? val[15:0] : 16'($urandom);
  endtask
  task automatic set_cfg(input int s0, input int s1, input int st, input int ov, input int rt, input int sel);
    cfg_delay_start = s0[7:0];
    cfg_delay_stop = s1[7:0];
    cfg_delay_step = st[7:0];
    cfg_overlay = ov[0];
    cfg_rate = rt[0];
    cfg_filter_sel = sel[2:0];
  endtask
  task automatic scramble_cfg();
    set_cfg(int'($urandom), int'($urandom), int'($urandom), int'($urandom), int'($urandom), int'($urandom));
  endtask
  task automatic run_sweep(input int s0, input int s1, input int st, input int ov, input int rt,
                           input int sel, input int mode, input int bp_step, input int bp_len);
    int exp_d[$];
    int win[WL];
    int d, nx, stp, pk, ix;
    logic [FW-1:0] ep;
    stp = (st == 0) ? 1 : st;
    d = s0;
    forever begin
      exp_d.push_back(d);
      nx = d + stp;
      if (nx > s1 || nx > 255 || s0 > s1) break;
      d = nx;
    end
    set_cfg(s0, s1, st, ov, rt, sel);
    start = 1;
    tick();
    start = 0;
    scramble_cfg();
    chk("busy_start", busy, 1);
    chk("delay_start", test_delay, s0);
    chk("overlay_busy", test_overlay, ov);
    chk("rate_busy", test_rate, rt);
    for (int n = 0; n < exp_d.size(); n++) begin
      for (int i = 0; i < SL; i++) begin
        drive(sel, int'($urandom));
        tick();
      end
      for (int j = 0; j < WL; j++)
        win[j] = mode == 0 ? int'($urandom_range(0, 40)) - 20 :
                 mode == 1 ? ((j == 17 || j == 40) ? 300 : -5) : -32768;
      pk = -32768;
      foreach (win[j]) if (win[j] > pk) pk = win[j];
      ix = -1;
      foreach (win[j]) if (ix < 0 && win[j] == pk) ix = j;
      ep = pk[15:0];
      for (int j = 0; j < WL; j++) begin
        drive(sel, win[j]);
        if (j == WL - 1) chk("valid_early", result_valid, 0);
        tick();
      end
      chk("valid", result_valid, 1);
      chk("rdelay", result_delay, exp_d[n]);
      chk("peak", result_peak, ep);
      chk("idx", result_peak_idx, ix);
      if (n == bp_step)
        for (int b = 0; b < bp_len; b++) begin
          drive(sel, 32767);
          tick();
          chk("bp_valid", result_valid, 1);
          chk("bp_delay", result_delay, exp_d[n]);
          chk("bp_peak", result_peak, ep);
          chk("bp_idx", result_peak_idx, ix);
        end
      result_ready = 1;
      tick();
      result_ready = 0;
      if (n == exp_d.size() - 1) begin
        chk("done_pulse", done, 1);
        chk("busy_finish", busy, 1);
        chk("valid_finish", result_valid, 0);
        tick();
        chk("done_clear", done, 0);
        chk("busy_idle", busy, 0);
        chk("overlay_idle", test_overlay, 0);
        chk("rate_idle", test_rate, 0);
        chk("delay_hold", test_delay, exp_d[n]);
      end else begin
        chk("done_mid", done, 0);
        chk("busy_mid", busy, 1);
        chk("valid_drop", result_valid, 0);
        chk("delay_next", test_delay, exp_d[n+1]);
      end
    end
  endtask
  initial begin
    int bad;
    tick();
    chk("reset_outs", outs(), 0);
    reset = 0;
    tick();
    chk("idle_outs", outs(), 0);
    run_sweep(0, 4, 2, 1, 0, 1, 0, -1, 0);
    run_sweep(5, 5, 1, 1, 1, 1, 1, -1, 0);
    run_sweep(7, 7, 1, 0, 1, 3, 2, -1, 0);
    run_sweep(10, 20, 10, 0, 1, 4, 0, 0, 50);
    run_sweep(250, 255, 10, 1, 0, 5, 0, -1, 0);
    run_sweep(3, 5, 0, 0, 0, 0, 0, 1, 3);
    run_sweep(9, 2, 1, 1, 1, 2, 0, -1, 0);
    set_cfg(1, 9, 1, 1, 1, 6);
    start = 1;
    tick();
    start = 0;
    chk("cfg_err_pulse", cfg_error, 1);
    chk("cfg_err_busy", busy, 0);
    tick();
    chk("cfg_err_clear", cfg_error, 0);
    set_cfg(1, 9, 1, 1, 1, 0);
    start = 1;
    abort = 1;
    tick();
    start = 0;
    abort = 0;
    chk("abort_beats_start", busy, 0);
    chk("abort_start_err", cfg_error, 0);
    set_cfg(1, 9, 1, 1, 1, 2);
    start = 1;
    tick();
    start = 0;
    for (int i = 0; i < SL + 100; i++) begin
      drive(2, int'($urandom));
      tick();
    end
    chk("abort_pre_busy", busy, 1);
    abort = 1;
    tick();
    abort = 0;
    chk("abort_busy", busy, 0);
    chk("abort_overlay", test_overlay, 0);
    chk("abort_rate", test_rate, 0);
    chk("abort_valid", result_valid, 0);
    bad = 0;
    for (int i = 0; i < WL + SL + 20; i++) begin
      drive(2, int'($urandom));
      if (result_valid || done || busy) bad++;
      tick();
    end
    chk("abort_quiet", bad, 0);
    set_cfg(20, 40, 5, 1, 1, 0);
    start = 1;
    tick();
    start = 0;
    for (int i = 0; i < SL + WL; i++) begin
      drive(0, int'($urandom));
      tick();
    end
    chk("pre_reset_valid", result_valid, 1);
    #3 reset = 1;
    #1 chk("async_reset_outs", outs(), 0);
    #2 reset = 0;
    tick();
    chk("post_reset_idle", outs(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/filter_test_sequencer.md
# filter_test_sequencer

Sweep controller for the filter test bench. Drives the `exp_sig_gen` controls (`test_overlay`, `test_rate`, `test_delay`) through a programmed delay sweep. For each delay step it measures the peak and peak position of one selected filter output (V1..V6) over a fixed window. It returns one result record per step over a valid/ready handshake. It sits beside `exp_sig_gen` and the filter bank, and replaces static test-control pins.

## Interface
- `NUM_FILTERS`, 6, number of filter outputs on `filter_data`
- `SIZE_DELAY`, 8, width of delay control (matches `exp_sig_gen`)
- `SIZE_FILTER_DATA`, 16, width of each filter output, signed two's complement
- `SETTLE_LEN`, 16, cycles waited after a delay change before measuring (≥1)
- `WINDOW_LEN`, 256, measurement window in cycles (power of two, ≥2)

Ports:
- `clk` in 1 — single clock
- `reset` in 1 — asynchronous, active-high
- `start` in 1 — one-cycle request; sampled only in IDLE
- `abort` in 1 — stop the sweep; honored in any state
- `cfg_delay_start` in SIZE_DELAY — first delay value
- `cfg_delay_stop` in SIZE_DELAY — last delay value (inclusive)
- `cfg_delay_step` in SIZE_DELAY — increment; 0 is treated as 1
- `cfg_overlay` in 1 — overlay mode for the sweep
- `cfg_rate` in 1 — rate mode for the sweep
- `cfg_filter_sel` in 3 — filter index, 0..NUM_FILTERS-1
- `filter_data` in NUM_FILTERS*SIZE_FILTER_DATA — flattened filter outputs; filter k occupies bits [k*W +: W]
- `test_overlay` out 1 — to `exp_sig_gen`
- `test_rate` out 1 — to `exp_sig_gen`
- `test_delay` out SIZE_DELAY — to `exp_sig_gen`
- `result_valid` out 1 — result record available
- `result_ready` in 1 — consumer accepts the record
- `result_delay` out SIZE_DELAY — delay of the reported step
- `result_peak` out SIZE_FILTER_DATA — signed maximum in the window
- `result_peak_idx` out log2(WINDOW_LEN) — window offset of the first maximum
- `busy` out 1 — high in every state except IDLE
- `done` out 1 — one-cycle pulse when the sweep completes normally
- `cfg_error` out 1 — one-cycle pulse when a start is rejected

## Operation
- States: IDLE, SETTLE, MEASURE, REPORT, FINISH.
- IDLE, start=1, abort=0, sel<NUM_FILTERS:
  - latch all cfg_* inputs
  - `test_delay` ← `cfg_delay_start`
  - go to SETTLE
- IDLE, start=1, sel≥NUM_FILTERS: pulse `cfg_error`, stay in IDLE.
- SETTLE: count SETTLE_LEN cycles, then go to MEASURE. At MEASURE entry, peak ← most negative value and idx ← 0.
- MEASURE, every cycle for WINDOW_LEN cycles:
  - sample the selected `filter_data` lane
  - if the sample is strictly greater than the current peak, update peak and idx to the current window offset (0..WINDOW_LEN-1)
  - the last sample is included; then go to REPORT
- REPORT: `result_valid`=1, with `result_*` stable until a cycle where `result_valid`&&`result_ready`. On that handshake:
  - next = current + step (computed SIZE_DELAY+1 wide)
  - if next > stop, or next carries out of SIZE_DELAY, or start > stop: go to FINISH
  - otherwise `test_delay` ← next and go to SETTLE
- FINISH: `done`=1 for one cycle, then IDLE.
- `test_overlay` and `test_rate` equal the latched cfg while `busy`, and 0 in IDLE. `test_delay` holds its last value in IDLE.
- `abort` (any state): next state IDLE, `result_valid` cleared, no `done` pulse.
  - abort beats start in the same cycle
  - abort beats a same-cycle handshake; that record counts as dropped
- cfg_* changes while `busy` have no effect.

## Timing
- Reset values: all outputs 0; state IDLE.
- Start accepted at edge T: `busy`=1 and `test_delay`=start value from T+1.
- The first MEASURE sample is at cycle T+1+SETTLE_LEN.
- `result_valid` rises at T+1+SETTLE_LEN+WINDOW_LEN.
- After a handshake at edge H, the next step's SETTLE begins at H+1.
- Per-step latency with no backpressure: SETTLE_LEN+WINDOW_LEN+1 cycles.
- `done` is asserted in the cycle after the final handshake; `busy` falls one cycle later.
- The input sample is used in the same cycle it is presented. There are no internal pipeline stages on `filter_data`.

## Test plan
- Basic sweep: start=0, stop=4, step=2, sel=1, ready tied 1.
  - exactly 3 records, delays 0, 2, 4
  - `done` 1 cycle after the third handshake
  - 3×(SETTLE_LEN+WINDOW_LEN+1) cycles total
- Peak capture: drive lane 1 with −5 everywhere, +300 at offsets 17 and 40 → peak=300, idx=17. All samples −32768 → peak=−32768, idx=0.
- Backpressure: hold ready=0 for 50 cycles in REPORT → `result_*` constant for 50 cycles; the next SETTLE starts the cycle after ready=1.
- Boundary: start=250, stop=255, step=10 → single record (delay 250), no wrap. step=0 with start=3, stop=5 → delays 3, 4, 5. start=9, stop=2 → single record (delay 9).
- Error and abort:
  - sel=6 → `cfg_error` pulse, `busy` stays 0
  - abort mid-MEASURE → IDLE next cycle, no record, no `done`, `test_overlay`/`test_rate`=0
- Async reset asserted in REPORT → all outputs 0 immediately, without waiting for a clock edge.
